// File: rtl/cb_pkg.sv
// Shared constants, field-layout helpers and loader state type for the cb_scan
// connection box. Defaults mirror the top-level parameter defaults.
package cb_pkg;

    typedef enum logic {
        LOAD   = 1'b0,
        COMMIT = 1'b1
    } ld_state_e;

    function automatic int single_sel_w(input int chn_width, input int clb_owidth);
        return $clog2(chn_width + 2 * clb_owidth + 1);
    endfunction

    function automatic int clb_sel_w(input int chn_width, input int clb_owidth);
        return $clog2(clb_owidth + 2 * chn_width + 1);
    endfunction

    function automatic int cfg_size_of(input int chn_width, input int clb_iwidth,
                                       input int s_w, input int c_w);
        return 2 * chn_width * (s_w + 1) + 2 * clb_iwidth * (c_w + 1);
    endfunction

    function automatic int nwords_of(input int cfg_size, input int cfg_word);
        return (cfg_size + cfg_word - 1) / cfg_word;
    endfunction

    // k indexes single0_out bits first, then single1_out bits
    function automatic int single_off(input int s_w, input int k);
        return k * (s_w + 1);
    endfunction

    // j indexes clb0_input bits first, then clb1_input bits
    function automatic int clb_off(input int chn_width, input int s_w, input int c_w, input int j);
        return 2 * chn_width * (s_w + 1) + j * (c_w + 1);
    endfunction

    localparam int S        = single_sel_w(16, 4);
    localparam int C        = clb_sel_w(16, 4);
    localparam int CFG_SIZE = cfg_size_of(16, 10, S, C);
    localparam int NWORDS   = nwords_of(CFG_SIZE, 8);

endpackage

// File: rtl/MUXN.sv
// Generic N-input single-bit multiplexer; selects beyond the last input give 0.
module MUXN #(
    parameter int N    = 2,
    parameter int SELW = 1
) (
    input  logic [N-1:0]    in_vec,
    input  logic [SELW-1:0] sel,
    output logic            out
);

    assign out = (int'(sel) < N) ? in_vec[sel] : 1'b0;

endmodule

// File: rtl/cb_cfg_loader.sv
// Word-serial configuration loader: shifts words into a shadow register and
// commits a complete image to the active configuration in one cycle.
module cb_cfg_loader
    import cb_pkg::*;
#(
    parameter int CFG_WORD = 8,
    parameter int CFG_SIZE = 332,
    parameter int NWORDS   = 42
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    input  logic [CFG_WORD-1:0] cfg_data,
    input  logic                cfg_clear,
    output logic                cfg_ready,
    output logic                cfg_done,
    output logic                cfg_loaded,
    output logic [CFG_SIZE-1:0] active_cfg
);

    localparam int CNTW = $clog2(NWORDS + 1);
    localparam int SHW  = NWORDS * CFG_WORD;

    ld_state_e         state_r, state_s;
    logic [CNTW-1:0]   cnt_r, cnt_s;
    logic [SHW-1:0]    shadow_r;
    logic              accept_s;
    logic              loaded_r;
    logic [CFG_SIZE-1:0] active_r;

    // Next-state, counter and handshake decode
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        cfg_ready = 1'b0;
        accept_s  = 1'b0;
        case (state_r)
            LOAD: begin
                cfg_ready = ~cfg_clear;
                accept_s  = cfg_valid & ~cfg_clear;
                if (cfg_clear) begin
                    cnt_s = {CNTW{1'b0}};
                end else if (accept_s) begin
                    if (cnt_r == CNTW'(NWORDS - 1)) begin
                        state_s = COMMIT;
                    end else begin
                        cnt_s = cnt_r + CNTW'(1);
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            COMMIT: begin
                cnt_s   = {CNTW{1'b0}};
                state_s = LOAD;
            end
            default: begin
                cnt_s   = {CNTW{1'b0}};
                state_s = LOAD;
            end
        endcase
    end

    // Loader state, shadow shift register and active image
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= LOAD;
            cnt_r    <= {CNTW{1'b0}};
            shadow_r <= {SHW{1'b0}};
            active_r <= {CFG_SIZE{1'b0}};
            loaded_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (accept_s) begin
                shadow_r <= {cfg_data, shadow_r[SHW-1:CFG_WORD]};
            end else begin
                shadow_r <= shadow_r;
            end
            if (state_r == COMMIT) begin
                active_r <= shadow_r[CFG_SIZE-1:0];
                loaded_r <= 1'b1;
            end else begin
                active_r <= active_r;
                loaded_r <= loaded_r;
            end
        end
    end

    // Pad bits of the last word carry no configuration
    if (SHW > CFG_SIZE) begin : g_pad
        logic pad_unused;
        assign pad_unused = ^shadow_r[SHW-1:CFG_SIZE];
    end

    assign cfg_done   = (state_r == COMMIT);
    assign cfg_loaded = loaded_r;
    assign active_cfg = active_r;

endmodule

// File: rtl/cb_scan.sv
// Configurable connection box between two CLBs and two single-track channels;
// every output bit has its own select and optional output register.
module cb_scan
    import cb_pkg::*;
#(
    parameter int CLB_IWIDTH = 10,
    parameter int CLB_OWIDTH = 4,
    parameter int CHN_WIDTH  = 16,
    parameter int CFG_WORD   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CLB_OWIDTH-1:0] clb0_output,
    input  logic [CLB_OWIDTH-1:0] clb1_output,
    output logic [CLB_IWIDTH-1:0] clb0_input,
    output logic [CLB_IWIDTH-1:0] clb1_input,
    input  logic [CHN_WIDTH-1:0]  single0_in,
    input  logic [CHN_WIDTH-1:0]  single1_in,
    output logic [CHN_WIDTH-1:0]  single0_out,
    output logic [CHN_WIDTH-1:0]  single1_out,
    input  logic                  cfg_valid,
    input  logic [CFG_WORD-1:0]   cfg_data,
    output logic                  cfg_ready,
    input  logic                  cfg_clear,
    output logic                  cfg_done,
    output logic                  cfg_loaded
);

    localparam int SW    = single_sel_w(CHN_WIDTH, CLB_OWIDTH);
    localparam int CW    = clb_sel_w(CHN_WIDTH, CLB_OWIDTH);
    localparam int CSIZE = cfg_size_of(CHN_WIDTH, CLB_IWIDTH, SW, CW);
    localparam int NW    = nwords_of(CSIZE, CFG_WORD);
    localparam int NS    = CHN_WIDTH + 2 * CLB_OWIDTH + 1;
    localparam int NC    = CLB_OWIDTH + 2 * CHN_WIDTH + 1;

    logic [CSIZE-1:0] active_cfg;

    logic [NS-1:0] src_s0, src_s1;
    logic [NC-1:0] src_c0, src_c1;

    logic [CHN_WIDTH-1:0]  s0_mux, s1_mux, s0_q, s1_q, s0_en, s1_en;
    logic [CLB_IWIDTH-1:0] c0_mux, c1_mux, c0_q, c1_q, c0_en, c1_en;

    cb_cfg_loader #(
        .CFG_WORD (CFG_WORD),
        .CFG_SIZE (CSIZE),
        .NWORDS   (NW)
    ) u_loader (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_data   (cfg_data),
        .cfg_clear  (cfg_clear),
        .cfg_ready  (cfg_ready),
        .cfg_done   (cfg_done),
        .cfg_loaded (cfg_loaded),
        .active_cfg (active_cfg)
    );

    // Index 0 of every source vector is the constant-zero input
    assign src_s0 = {single1_in, clb1_output, clb0_output, 1'b0};
    assign src_s1 = {single0_in, clb1_output, clb0_output, 1'b0};
    assign src_c0 = {clb1_output, single1_in, single0_in, 1'b0};
    assign src_c1 = {clb0_output, single1_in, single0_in, 1'b0};

    for (genvar i = 0; i < CHN_WIDTH; i++) begin : g_single
        MUXN #(.N(NS), .SELW(SW)) u_s0 (
            .in_vec (src_s0),
            .sel    (active_cfg[single_off(SW, i) +: SW]),
            .out    (s0_mux[i])
        );
        MUXN #(.N(NS), .SELW(SW)) u_s1 (
            .in_vec (src_s1),
            .sel    (active_cfg[single_off(SW, i + CHN_WIDTH) +: SW]),
            .out    (s1_mux[i])
        );
        assign s0_en[i] = active_cfg[single_off(SW, i) + SW];
        assign s1_en[i] = active_cfg[single_off(SW, i + CHN_WIDTH) + SW];
    end

    for (genvar j = 0; j < CLB_IWIDTH; j++) begin : g_clb
        MUXN #(.N(NC), .SELW(CW)) u_c0 (
            .in_vec (src_c0),
            .sel    (active_cfg[clb_off(CHN_WIDTH, SW, CW, j) +: CW]),
            .out    (c0_mux[j])
        );
        MUXN #(.N(NC), .SELW(CW)) u_c1 (
            .in_vec (src_c1),
            .sel    (active_cfg[clb_off(CHN_WIDTH, SW, CW, j + CLB_IWIDTH) +: CW]),
            .out    (c1_mux[j])
        );
        assign c0_en[j] = active_cfg[clb_off(CHN_WIDTH, SW, CW, j) + CW];
        assign c1_en[j] = active_cfg[clb_off(CHN_WIDTH, SW, CW, j + CLB_IWIDTH) + CW];
    end

    // Output registers capture every mux result each cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_q <= {CHN_WIDTH{1'b0}};
            s1_q <= {CHN_WIDTH{1'b0}};
            c0_q <= {CLB_IWIDTH{1'b0}};
            c1_q <= {CLB_IWIDTH{1'b0}};
        end else begin
            s0_q <= s0_mux;
            s1_q <= s1_mux;
            c0_q <= c0_mux;
            c1_q <= c1_mux;
        end
    end

    assign single0_out = (s0_en & s0_q) | (~s0_en & s0_mux);
    assign single1_out = (s1_en & s1_q) | (~s1_en & s1_mux);
    assign clb0_input  = (c0_en & c0_q) | (~c0_en & c0_mux);
    assign clb1_input  = (c1_en & c1_q) | (~c1_en & c1_mux);

endmodule

// File: tb/tb_cb_scan.sv
// Scoreboard bench for cb_scan: a behavioural model predicts every output per
// cycle, a negedge monitor pops predictions and compares.
module tb_cb_scan;

    localparam int NOUT  = 52;
    localparam int NW    = 42;
    localparam int CSIZE = 332;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  clb0_output = 4'h0, clb1_output = 4'h0;
    logic [9:0]  clb0_input, clb1_input;
    logic [15:0] single0_in = 16'h0, single1_in = 16'h0;
    logic [15:0] single0_out, single1_out;
    logic        cfg_valid = 1'b0, cfg_clear = 1'b0;
    logic [7:0]  cfg_data = 8'h0;
    logic        cfg_ready, cfg_done, cfg_loaded;

    always #5 clk = ~clk;

    cb_scan dut (
        .clk(clk), .rst_n(rst_n),
        .clb0_output(clb0_output), .clb1_output(clb1_output),
        .clb0_input(clb0_input), .clb1_input(clb1_input),
        .single0_in(single0_in), .single1_in(single1_in),
        .single0_out(single0_out), .single1_out(single1_out),
        .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
        .cfg_clear(cfg_clear), .cfg_done(cfg_done), .cfg_loaded(cfg_loaded)
    );

    typedef struct {
        logic [15:0] s0, s1;
        logic [9:0]  c0, c1;
        logic        rdy, done, loaded;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int bad = 0;

    // Model state
    int         m_sel[NOUT];
    bit         m_en[NOUT];
    bit         m_prev[NOUT];
    bit         m_loaded, m_commit;
    int         m_cnt;
    logic [7:0] m_words[$];

    // Stimulus config
    int         cfg_sel[NOUT];
    bit         cfg_en[NOUT];
    logic [7:0] wbuf[NW];

    // Source list in select order: index 0 is constant zero
    function automatic bit src_bit(int k, int sel, logic [15:0] a0, logic [15:0] a1,
                                   logic [3:0] o0, logic [3:0] o1);
        bit q[$];
        q.push_back(1'b0);
        if (k < 32) begin
            for (int i = 0; i < 4; i++) q.push_back(o0[i]);
            for (int i = 0; i < 4; i++) q.push_back(o1[i]);
            for (int i = 0; i < 16; i++) q.push_back(k < 16 ? a1[i] : a0[i]);
        end else begin
            for (int i = 0; i < 16; i++) q.push_back(a0[i]);
            for (int i = 0; i < 16; i++) q.push_back(a1[i]);
            for (int i = 0; i < 4; i++) q.push_back(k < 42 ? o1[i] : o0[i]);
        end
        if (sel < q.size()) return q[sel];
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NOUT; k++) begin
            m_sel[k] = 0; m_en[k] = 1'b0; m_prev[k] = 1'b0;
        end
        m_loaded = 1'b0; m_commit = 1'b0; m_cnt = 0;
        m_words.delete();
    endtask

    // Image = last 42 words, first word at the LSB
    task automatic model_commit();
        logic [NW*8-1:0] b;
        for (int j = 0; j < NW; j++) b[j*8 +: 8] = m_words[m_words.size() - NW + j];
        for (int k = 0; k < 32; k++) begin
            m_sel[k] = int'(b[k*6 +: 5]);
            m_en[k]  = b[k*6 + 5];
        end
        for (int j = 0; j < 20; j++) begin
            m_sel[32+j] = int'(b[192 + j*7 +: 6]);
            m_en[32+j]  = b[192 + j*7 + 6];
        end
    endtask

    task automatic random_cfg();
        for (int k = 0; k < NOUT; k++) begin
            cfg_sel[k] = (k < 32) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 63));
            cfg_en[k]  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic encode_cfg();
        logic [NW*8-1:0] b;
        b = {NW{8'($urandom)}};
        for (int k = 0; k < 32; k++) begin
            b[k*6 +: 5] = 5'(cfg_sel[k]);
            b[k*6 + 5]  = cfg_en[k];
        end
        for (int j = 0; j < 20; j++) begin
            b[192 + j*7 +: 6] = 6'(cfg_sel[32+j]);
            b[192 + j*7 + 6]  = cfg_en[32+j];
        end
        for (int j = 0; j < NW; j++) wbuf[j] = b[j*8 +: 8];
    endtask

    // One clock cycle: drive, predict, push expectation, advance model
    task automatic cycle(input bit rst, input bit v, input logic [7:0] d, input bit clr,
                         input logic [15:0] a0, input logic [15:0] a1,
                         input logic [3:0] o0, input logic [3:0] o1);
        exp_t e;
        bit cur[NOUT];
        bit outv[NOUT];
        @(posedge clk);
        #1;
        rst_n = ~rst; cfg_valid = v; cfg_data = d; cfg_clear = clr;
        single0_in = a0; single1_in = a1; clb0_output = o0; clb1_output = o1;
        if (rst) model_reset();
        for (int k = 0; k < NOUT; k++) begin
            cur[k]  = src_bit(k, m_sel[k], a0, a1, o0, o1);
            outv[k] = m_en[k] ? m_prev[k] : cur[k];
        end
        for (int i = 0; i < 16; i++) begin
            e.s0[i] = outv[i]; e.s1[i] = outv[16+i];
        end
        for (int i = 0; i < 10; i++) begin
            e.c0[i] = outv[32+i]; e.c1[i] = outv[42+i];
        end
        e.rdy = m_commit ? 1'b0 : ~clr;
        e.done = m_commit;
        e.loaded = m_loaded;
        sbq.push_back(e);
        if (!rst) begin
            for (int k = 0; k < NOUT; k++) m_prev[k] = cur[k];
            if (m_commit) begin
                model_commit();
                m_loaded = 1'b1; m_commit = 1'b0; m_cnt = 0;
            end else if (clr) begin
                m_cnt = 0;
            end else if (v) begin
                m_words.push_back(d);
                m_cnt++;
                if (m_cnt == NW) m_commit = 1'b1;
            end
        end
    endtask

    task automatic rcycle(input bit rst, input bit v, input logic [7:0] d, input bit clr);
        cycle(rst, v, d, clr, 16'($urandom), 16'($urandom), 4'($urandom), 4'($urandom));
    endtask

    // Send n words of wbuf; gaps insert idle cycles; hold keeps valid high
    task automatic send_words(input int n, input bit gaps);
        int j = 0;
        while (j < n) begin
            bit v;
            bit will_take;
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            will_take = v && !m_commit;
            rcycle(1'b0, v, wbuf[j], 1'b0);
            if (will_take) j++;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Monitor: compare DUT outputs with the oldest prediction
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("single0_out", 32'(single0_out), 32'(e.s0));
            chk("single1_out", 32'(single1_out), 32'(e.s1));
            chk("clb0_input",  32'(clb0_input),  32'(e.c0));
            chk("clb1_input",  32'(clb1_input),  32'(e.c1));
            chk("cfg_ready",   32'(cfg_ready),   32'(e.rdy));
            chk("cfg_done",    32'(cfg_done),    32'(e.done));
            chk("cfg_loaded",  32'(cfg_loaded),  32'(e.loaded));
        end
    end

    initial begin
        model_reset();
        // Reset, then idle with no load
        rcycle(1'b1, 1'b0, 8'h00, 1'b0);
        rcycle(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (5) rcycle(1'b0, 1'b0, 8'h00, 1'b0);

        // Combinational route single1_in[3] -> single0_out[0], clb0_output[1] -> clb1_input[2]
        random_cfg();
        cfg_sel[0] = 12; cfg_en[0] = 1'b0;
        cfg_sel[44] = 34; cfg_en[44] = 1'b0;
        cfg_sel[37] = 63; cfg_en[37] = 1'b0;
        encode_cfg();
        send_words(NW, 1'b0);
        repeat (2) rcycle(1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 16'h0008, 4'h2, 4'h0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 16'h0000, 4'h0, 4'hF);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 16'hFFFF, 16'hFFFF, 4'hF, 4'hF);

        // Same route, registered
        cfg_en[0] = 1'b1;
        encode_cfg();
        send_words(NW, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 16'h0000, 4'h0, 4'h0);
        repeat (2) cycle(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 16'h0008, 4'h0, 4'h0);
        repeat (2) cycle(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 16'h0000, 4'h0, 4'h0);

        // Partial load aborted by clear (clear wins over valid), then full load
        random_cfg(); encode_cfg();
        send_words(20, 1'b1);
        repeat (3) rcycle(1'b0, 1'b0, 8'h00, 1'b0);
        rcycle(1'b0, 1'b1, 8'hA5, 1'b1);
        random_cfg(); encode_cfg();
        send_words(NW, 1'b1);
        repeat (4) rcycle(1'b0, 1'b0, 8'h00, 1'b0);

        // Reset during word 30, then full load with valid held through commit
        random_cfg(); encode_cfg();
        send_words(29, 1'b0);
        rcycle(1'b1, 1'b1, wbuf[29], 1'b0);
        random_cfg(); encode_cfg();
        send_words(NW, 1'b0);
        repeat (3) rcycle(1'b0, 1'b1, 8'($urandom), 1'b0);
        rcycle(1'b0, 1'b0, 8'h00, 1'b1);
        repeat (3) rcycle(1'b0, 1'b0, 8'h00, 1'b0);

        // Random loads with random traffic
        for (int r = 0; r < 6; r++) begin
            random_cfg(); encode_cfg();
            send_words(NW, 1'b1);
            repeat (15) rcycle(1'b0, 1'b0, 8'h00, 1'b0);
        end

        // Drain the scoreboard with a bound
        for (int t = 0; t < 10 && sbq.size() > 0; t++) @(posedge clk);
        if (sbq.size() > 0) begin
            total++; bad++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
